uart_rx_port: RTL and testbench

- Hardware UART receiver: 8N1, LSB first, idle-high line.
- Samples the asynchronous RX pin in the clk_core domain and buffers complete bytes in a small first-word-fall-through FIFO.
- The CFM core drains the FIFO through a pop strobe and reads error flags.
- Sits between the board-level RX pin and the core's input-port mux; it is the receive counterpart to the core's software-driven TX path.

---
 rtl/uart_rx_port_pkg.sv | 31 +++
 rtl/uart_rx_port_sync_fifo.sv | 80 ++++++++
 rtl/uart_rx_port.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_rx_port.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_port_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_port_pkg
// Shared definitions for the UART receive port. A future uart_tx_port can
// import the same package.
//   - rx_state_t      : receiver FSM state encoding (3 bits)
//   - DATA_BITS       : data bits per frame (8N1)
//   - DEFAULT_DIVISOR : clk_core cycles per bit for a 48 MHz core at 115200 baud
//   - DEFAULT_DEPTH   : default receive FIFO depth
//   - half_bit_reload : counter reload that lands a sample in mid start bit
// -----------------------------------------------------------------------------
package uart_rx_port_pkg;

  localparam int DATA_BITS       = 8;
  localparam int DEFAULT_DIVISOR = 416;
  localparam int DEFAULT_DEPTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

  // Integer division is intentional: for odd divisors the start-bit sample
  // sits half a cycle early, which is harmless.
  function automatic int half_bit_reload(input int divisor);
    return (divisor / 2) - 1;
  endfunction

endpackage

// File: rtl/uart_rx_port_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
// Parameters:
//   WIDTH : word width
//   DEPTH : number of entries (power of two, >= 2)
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset (empties the FIFO)
//   i_push  : write i_wdata; ignored when full unless a pop happens too
//   i_wdata : write data
//   i_pop   : remove the head word; ignored when empty
//   o_head  : head word, combinational; all zeros when empty
//   o_full  : DEPTH words held
//   o_empty : no words held
// Handshake: a word is accepted on a rising edge where i_push=1 and
// (o_full=0 or an effective pop occurs in the same cycle); a word is removed
// on a rising edge where i_pop=1 and o_empty=0. There is no back-pressure
// beyond o_full, so the producer must check it.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop on a full FIFO frees the slot the simultaneous push will use.
  assign w_pop  = i_pop & ~w_empty;
  assign w_push = i_push & (~w_full | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers alone define which words are live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/uart_rx_port.sv
// -----------------------------------------------------------------------------
// uart_rx_port
// UART receiver, 8N1, LSB first, idle-high line. The asynchronous rx pin is
// brought into clk_core through a two-flop synchronizer; complete bytes are
// queued in a first-word-fall-through FIFO that the core drains with rd_en.
// Parameters:
//   DIVISOR : clk_core cycles per bit (>= 4)
//   DEPTH   : FIFO entries (power of two, >= 2)
// Ports:
//   clk_core    : core clock, all state on its rising edge
//   reset       : asynchronous active-high reset
//   rx          : raw serial line, asynchronous to clk_core
//   rd_en       : pop strobe; removes the head byte when rx_valid=1
//   err_clr     : clears the sticky error flags
//   rx_data     : head-of-FIFO byte, 8'h00 when empty
//   rx_valid    : FIFO non-empty
//   rx_full     : FIFO holds DEPTH bytes
//   overrun     : sticky, a byte was dropped because the FIFO was full
//   framing_err : sticky, a stop bit was sampled low
//   busy        : receiver is not idle
//   state_dbg   : current receiver FSM state (rx_state_t encoding)
// Handshake: the core sees a byte while rx_valid=1; asserting rd_en on a
// rising edge with rx_valid=1 consumes it, and rd_en while rx_valid=0 is
// ignored. The receiver itself cannot be stalled: a byte that completes while
// the FIFO is full is accepted only if a pop happens in that same cycle.
// -----------------------------------------------------------------------------
module uart_rx_port
  import uart_rx_port_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       overrun,
  output logic       framing_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int                CNT_W    = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(half_bit_reload(DIVISOR));
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DIVISOR - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both stages reset high so reset never looks like a
  // start bit.
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // ---------------------------------------------------------------------------
  // Receiver FSM: state register
  // ---------------------------------------------------------------------------
  rx_state_t              r_state;
  rx_state_t              w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [2:0]             r_bitcnt;
  logic [2:0]             w_bitcnt_next;
  logic [DATA_BITS-1:0]   r_shreg;
  logic [DATA_BITS-1:0]   w_shreg_next;

  logic                   w_push;
  logic                   w_set_overrun;
  logic                   w_set_framing;
  logic                   w_cnt_zero;

  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_pop_eff;

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_bitcnt <= w_bitcnt_next;
      r_shreg  <= w_shreg_next;
    end
  end

  assign w_cnt_zero = (r_cnt == '0);
  assign w_pop_eff  = rd_en & ~w_fifo_empty;

  // ---------------------------------------------------------------------------
  // Receiver FSM: next state and per-cycle strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_bitcnt_next = r_bitcnt;
    w_shreg_next  = r_shreg;
    w_push        = 1'b0;
    w_set_overrun = 1'b0;
    w_set_framing = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          // Half a bit later the sample lands in the middle of the start bit.
          w_cnt_next   = CNT_HALF;
          w_state_next = ST_START;
        end
      end

      ST_START: begin
        if (w_cnt_zero) begin
          if (!w_rx_s) begin
            w_cnt_next    = CNT_FULL;
            w_bitcnt_next = '0;
            w_state_next  = ST_DATA;
          end else begin
            // Line went back high before mid-bit: a glitch, not a frame.
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      ST_DATA: begin
        if (w_cnt_zero) begin
          // LSB arrives first, so shift right and insert at the top.
          w_shreg_next = {w_rx_s, r_shreg[DATA_BITS-1:1]};
          w_cnt_next   = CNT_FULL;
          if (r_bitcnt == LAST_BIT) begin
            w_state_next = ST_STOP;
          end else begin
            w_bitcnt_next = r_bitcnt + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      ST_STOP: begin
        if (w_cnt_zero) begin
          if (w_rx_s) begin
            if (!w_fifo_full || w_pop_eff) begin
              w_push = 1'b1;
            end else begin
              w_set_overrun = 1'b1;
            end
            w_state_next = ST_IDLE;
          end else begin
            // A low stop bit means a break or a baud mismatch; wait for the
            // line to recover so a long break is not decoded as new frames.
            w_set_framing = 1'b1;
            w_state_next  = ST_WAIT_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set in the same cycle as err_clr wins.
  // ---------------------------------------------------------------------------
  logic r_overrun;
  logic r_framing_err;

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      r_overrun     <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      if (w_set_overrun) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_set_framing) begin
        r_framing_err <= 1'b1;
      end else if (err_clr) begin
        r_framing_err <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] w_head;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_core),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_wdata (r_shreg),
    .i_pop   (rd_en),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_data     = w_head;
  assign rx_valid    = ~w_fifo_empty;
  assign rx_full     = w_fifo_full;
  assign overrun     = r_overrun;
  assign framing_err = r_framing_err;
  assign busy        = (r_state != ST_IDLE);
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_uart_rx_port.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_port
// Self-checking bench for uart_rx_port with DIVISOR=16, DEPTH=4. Serial frames
// are driven on rx; a reference model tracks which bytes the FIFO should hold
// and pushes them into exp_q. A monitor compares the DUT head byte against
// exp_q every time the bench pops with rd_en.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_port;

  localparam int DIV   = 16;
  localparam int DEP   = 4;
  localparam int FRAME = 10 * DIV;
  // Start edge on rx -> rx_valid: 2 sync + half bit + 9 bits + 1 for FIFO.
  localparam int LATENCY = 2 + DIV / 2 + 9 * DIV + 1;
  // Ticks from driving a start bit to just before its stop-sample edge.
  localparam int STOP_SAMPLE_TICKS = LATENCY - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk_core = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full;
  logic       overrun;
  logic       framing_err;
  logic       busy;
  logic [2:0] state_dbg;

  always #5 clk_core = ~clk_core;

  uart_rx_port #(
    .DIVISOR (DIV),
    .DEPTH   (DEP)
  ) dut (
    .clk_core    (clk_core),
    .reset       (reset),
    .rx          (rx),
    .rd_en       (rd_en),
    .err_clr     (err_clr),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_full     (rx_full),
    .overrun     (overrun),
    .framing_err (framing_err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         vectors    = 0;
  int         miscompares = 0;
  int         model_occ  = 0;
  logic       exp_ovr    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decide the fate of one complete, well-formed frame: it lands in the FIFO
  // if there is room, or if a pop frees a slot at the same moment.
  task automatic model_frame(input logic [7:0] b, input bit pop_same);
    if (model_occ < DEP || pop_same) begin
      exp_q.push_back(b);
      if (!pop_same) model_occ++;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_core);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low);
    rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) tick();
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (stop_low) tick();
    end
    rx = 1'b1;
    repeat (DIV) tick();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (model_occ > 0) model_occ--;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"},     rx_data,     0);
    check({tag, "_rx_valid"},    rx_valid,    0);
    check({tag, "_rx_full"},     rx_full,     0);
    check({tag, "_overrun"},     overrun,     0);
    check({tag, "_framing_err"}, framing_err, 0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_state"},       state_dbg,   0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every pop is checked against the expected queue
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_core);
      if (!reset && rd_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pop_valid", rx_valid, 1);
          check("pop_data",  rx_data,  e);
        end else begin
          check("empty_pop_valid", rx_valid, 0);
          check("empty_pop_data",  rx_data,  0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   lat;
    bit   hit;
    int   busy_cycles;
    int   npops;
    logic [7:0] b;

    reset   = 1'b1;
    rx      = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (4) tick();
    check_all_zero("post_reset");

    // ---- Single byte, exact latency ---------------------------------------
    model_frame(8'hA5, 0);
    hit = 0;
    lat = 0;
    fork
      send_byte(8'hA5, 0);
      begin
        for (int i = 0; i < 400 && !hit; i++) begin
          @(posedge clk_core);
          lat++;
          @(negedge clk_core);
          if (rx_valid) hit = 1;
        end
      end
    join
    check("latency_seen", hit, 1);
    check("latency", lat, LATENCY);
    check("a5_head", rx_data, 8'hA5);
    pop_one();
    check("a5_drained_valid", rx_valid, 0);
    check("a5_drained_data",  rx_data,  0);

    // ---- Short glitch on idle line ---------------------------------------
    busy_cycles = 0;
    fork
      begin
        rx = 1'b0;
        repeat (6) tick();
        rx = 1'b1;
      end
      begin
        repeat (30) begin
          @(negedge clk_core);
          if (busy) busy_cycles++;
        end
      end
    join
    check("glitch_busy_cycles", busy_cycles, DIV / 2);
    check("glitch_valid",   rx_valid,    0);
    check("glitch_overrun", overrun,     0);
    check("glitch_framing", framing_err, 0);
    check("glitch_state",   state_dbg,   0);

    // ---- Framing error with a long low stop bit ---------------------------
    fork
      send_byte(8'h3C, 40);
      begin
        repeat (STOP_SAMPLE_TICKS + 10) tick();
        check("break_state",   state_dbg,   4);
        check("break_busy",    busy,        1);
        check("break_framing", framing_err, 1);
        check("break_valid",   rx_valid,    0);
      end
    join
    repeat (4) tick();
    check("break_recovered_busy", busy,        0);
    check("break_sticky",         framing_err, 1);
    check("break_no_push",        rx_valid,    0);
    pulse_err_clr();
    check("framing_cleared", framing_err, 0);

    // ---- Overrun: five back-to-back bytes, err_clr at the dropping edge ---
    for (int i = 1; i <= 5; i++) model_frame(8'(i), 0);
    fork
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
      begin
        repeat (4 * FRAME) tick();
        check("ovr_full_after4",   rx_full, 1);
        check("ovr_clear_after4",  overrun, 0);
        repeat (STOP_SAMPLE_TICKS) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
      end
    join
    check("ovr_set_wins", overrun, exp_ovr);
    check("ovr_still_full", rx_full, 1);
    repeat (4) pop_one();
    check("ovr_drained", rx_valid, 0);
    pulse_err_clr();
    exp_ovr = 1'b0;
    check("ovr_cleared", overrun, 0);

    // ---- Full FIFO with a pop on the fifth stop-sample edge ---------------
    for (int i = 1; i <= 4; i++) model_frame(8'(i), 0);
    model_frame(8'h05, 1);
    fork
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
      begin
        repeat (4 * FRAME + STOP_SAMPLE_TICKS) tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
      end
    join
    check("popsame_overrun", overrun, exp_ovr);
    check("popsame_full",    rx_full, 1);
    repeat (4) pop_one();
    check("popsame_drained", rx_valid, 0);

    // ---- Reset in the middle of a frame -----------------------------------
    model_frame(8'h5A, 0);
    send_byte(8'h5A, 0);
    check("pre_reset_valid", rx_valid, 1);
    rx = 1'b0;
    repeat (DIV) tick();
    rx = 1'b1;
    repeat (3 * DIV + 4) tick();
    check("mid_frame_busy", busy, 1);
    reset = 1'b1;
    exp_q.delete();
    model_occ = 0;
    repeat (2) tick();
    check_all_zero("mid_reset");
    reset = 1'b0;
    repeat (6 * DIV) tick();
    check("after_reset_valid", rx_valid, 0);
    model_frame(8'h81, 0);
    send_byte(8'h81, 0);
    check("after_reset_count", rx_full, 0);
    pop_one();
    check("after_reset_drained", rx_valid, 0);

    // ---- Randomized frames with random draining ---------------------------
    for (int n = 0; n < 12; n++) begin
      npops = $urandom_range(0, model_occ + 1);
      repeat (npops) pop_one();
      repeat ($urandom_range(0, 12)) tick();
      b = 8'($urandom_range(0, 255));
      model_frame(b, 0);
      send_byte(b, 0);
    end
    check("rand_valid",   rx_valid,    (model_occ > 0));
    check("rand_full",    rx_full,     (model_occ == DEP));
    check("rand_overrun", overrun,     exp_ovr);
    check("rand_framing", framing_err, 0);
    npops = model_occ + 1;
    repeat (npops) pop_one();
    check("rand_drained", rx_valid, 0);

    repeat (4) tick();
    check("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
